jtag_bsr_chain: RTL and testbench

//  Boundary-scan register (BSR) feeding tap_top's bs_chain_tdi_i input.
//  - Serial path: tdi_i -> BSR_LEN cells -> tdo_o.
//  - Parallel capture from pins/core; parallel update latch drives output pads under EXTEST.
//  - Clocked on TCK; TAP-state strobes and IR-decode selects come from tap_top.

---
 rtl/jtag_bsr_chain_pkg.sv | 36 +++
 rtl/jtag_bsr_cell.sv | 50 +++++
 rtl/jtag_bsr_chain.sv | 56 +++++
 tb/tb_jtag_bsr_chain.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/jtag_bsr_chain_pkg.sv
// rtl/jtag_bsr_chain_pkg.sv - shared constants, strobe operation type and decode helper for the BSR chain
package jtag_bsr_chain_pkg;

    localparam int DEF_BSR_LEN = 8;
    localparam logic [7:0] DEF_OUT_MASK = 8'hF0;
    localparam logic [7:0] DEF_UPD_RST = 8'h00;

    // IR opcodes that select the boundary-scan register
    localparam logic [3:0] IR_EXTEST = 4'h0;
    localparam logic [3:0] IR_SAMPLE_PRELOAD = 4'h1;

    typedef enum logic [1:0] {
        BSR_OP_HOLD    = 2'd0,
        BSR_OP_CAPTURE = 2'd1,
        BSR_OP_SHIFT   = 2'd2,
        BSR_OP_UPDATE  = 2'd3
    } bsr_op_e;

    // Capture beats shift beats update; nothing happens unless the BSR is selected
    function automatic bsr_op_e bsr_decode(input logic sel, input logic cap,
                                           input logic sh, input logic upd);
        bsr_op_e op;
        op = BSR_OP_HOLD;
        if (sel) begin
            if (cap) begin
                op = BSR_OP_CAPTURE;
            end else if (sh) begin
                op = BSR_OP_SHIFT;
            end else if (upd) begin
                op = BSR_OP_UPDATE;
            end
        end
        return op;
    endfunction

endpackage

// File: rtl/jtag_bsr_cell.sv
// rtl/jtag_bsr_cell.sv - one boundary-scan cell: capture/shift flop, update flop, pad/core mux
module jtag_bsr_cell
    import jtag_bsr_chain_pkg::*;
#(
    parameter bit IS_OUT = 1'b0,
    parameter bit UPD_RST = 1'b0
) (
    input  logic tck,
    input  logic trst_n,
    input  bsr_op_e op,
    input  logic extest,
    input  logic serial_in,
    input  logic pad_val,
    input  logic core_val,
    output logic pad_drive,
    output logic core_drive,
    output logic serial_out
);

    logic shift_q;
    logic upd_q;

    // Capture/shift stage; the update stage only moves on an explicit update so SAMPLE is non-intrusive
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            shift_q <= 1'b0;
            upd_q   <= UPD_RST;
        end else begin
            case (op)
                BSR_OP_CAPTURE: shift_q <= IS_OUT ? core_val : pad_val;
                BSR_OP_SHIFT:   shift_q <= serial_in;
                BSR_OP_UPDATE:  upd_q   <= shift_q;
                default: ;
            endcase
        end
    end

    // Output cells pass core data to the pad unless EXTEST hands the pad to the update flop
    always_comb begin
        pad_drive  = 1'b0;
        core_drive = pad_val;
        if (IS_OUT) begin
            pad_drive  = extest ? upd_q : core_val;
            core_drive = core_val;
        end
    end

    assign serial_out = shift_q;

endmodule

// File: rtl/jtag_bsr_chain.sv
// rtl/jtag_bsr_chain.sv - boundary-scan register chain between TAP TDI and tap_top bs_chain_tdi_i
module jtag_bsr_chain
    import jtag_bsr_chain_pkg::*;
#(
    parameter int BSR_LEN = DEF_BSR_LEN,
    parameter logic [BSR_LEN-1:0] OUT_MASK = DEF_OUT_MASK,
    parameter logic [BSR_LEN-1:0] UPD_RST = DEF_UPD_RST
) (
    input  logic               tck_pad_i,
    input  logic               trst_pad_i,
    input  logic               tdi_i,
    input  logic               select_i,
    input  logic               extest_i,
    input  logic               capture_dr_i,
    input  logic               shift_dr_i,
    input  logic               update_dr_i,
    input  logic [BSR_LEN-1:0] pad_i,
    input  logic [BSR_LEN-1:0] core_i,
    output logic [BSR_LEN-1:0] pad_o,
    output logic [BSR_LEN-1:0] core_o,
    output logic               tdo_o
);

    // link[i+1] feeds cell i; link[0] is cell 0's shift flop, the bit nearest TDO
    logic [BSR_LEN:0] link;
    logic             extest_eff;
    bsr_op_e          op;

    assign link[BSR_LEN] = tdi_i;
    assign op = bsr_decode(select_i, capture_dr_i, shift_dr_i, update_dr_i);

    // While reset is held the pads must follow the core, whatever the IR says
    assign extest_eff = extest_i & trst_pad_i;

    // Held-reset cycles present 0 even before the first clock edge has cleared the flops
    assign tdo_o = trst_pad_i & link[0];

    for (genvar i = 0; i < BSR_LEN; i++) begin : g_cell
        jtag_bsr_cell #(
            .IS_OUT (OUT_MASK[i]),
            .UPD_RST(UPD_RST[i])
        ) u_cell (
            .tck       (tck_pad_i),
            .trst_n    (trst_pad_i),
            .op        (op),
            .extest    (extest_eff),
            .serial_in (link[i+1]),
            .pad_val   (pad_i[i]),
            .core_val  (core_i[i]),
            .pad_drive (pad_o[i]),
            .core_drive(core_o[i]),
            .serial_out(link[i])
        );
    end

endmodule

// File: tb/tb_jtag_bsr_chain.sv
// tb/tb_jtag_bsr_chain.sv - scoreboard bench for jtag_bsr_chain with a queue-based reference model
module tb_jtag_bsr_chain;

    localparam int N = 8;
    localparam logic [N-1:0] MASK = 8'hF0;
    localparam logic [N-1:0] URST = 8'h00;

    logic         tck = 1'b0;
    logic         trst = 1'b0;
    logic         tdi = 1'b0;
    logic         sel = 1'b0;
    logic         ext = 1'b0;
    logic         cap = 1'b0;
    logic         sh = 1'b0;
    logic         upd = 1'b0;
    logic [N-1:0] pad_in = '0;
    logic [N-1:0] core_in = '0;
    logic [N-1:0] pad_out;
    logic [N-1:0] core_out;
    logic         tdo;

    jtag_bsr_chain dut (
        .tck_pad_i   (tck),
        .trst_pad_i  (trst),
        .tdi_i       (tdi),
        .select_i    (sel),
        .extest_i    (ext),
        .capture_dr_i(cap),
        .shift_dr_i  (sh),
        .update_dr_i (upd),
        .pad_i       (pad_in),
        .core_i      (core_in),
        .pad_o       (pad_out),
        .core_o      (core_out),
        .tdo_o       (tdo)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic         tdo;
        logic [N-1:0] pad;
        logic [N-1:0] core;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: the chain is a bit queue whose front is the TDO end
    logic         mchain[$];
    logic [N-1:0] mupd;

    logic         seen_tdo;
    logic [N-1:0] seen_pad;

    function automatic void check(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endfunction

    // Monitor: every falling edge the DUT's outputs are compared to the oldest prediction
    always @(negedge tck) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("tdo_o", {7'b0, tdo}, {7'b0, e.tdo});
            check("pad_o", pad_out, e.pad);
            check("core_o", core_out, e.core);
        end
    end

    task automatic cycle(input logic r, input logic s, input logic x, input logic c,
                         input logic h, input logic u, input logic d,
                         input logic [N-1:0] pv, input logic [N-1:0] cv);
        exp_t e;
        trst = r; sel = s; ext = x; cap = c; sh = h; upd = u; tdi = d;
        pad_in = pv; core_in = cv;
        e.tdo = r ? mchain[0] : 1'b0;
        for (int i = 0; i < N; i++) begin
            if (MASK[i]) begin
                e.pad[i]  = (x && r) ? mupd[i] : cv[i];
                e.core[i] = cv[i];
            end else begin
                e.pad[i]  = 1'b0;
                e.core[i] = pv[i];
            end
        end
        exp_q.push_back(e);
        @(negedge tck);
        seen_tdo = tdo;
        seen_pad = pad_out;
        @(posedge tck);
        if (!r) begin
            for (int i = 0; i < N; i++) mchain[i] = 1'b0;
            mupd = URST;
        end else if (s) begin
            if (c) begin
                for (int i = 0; i < N; i++) mchain[i] = MASK[i] ? cv[i] : pv[i];
            end else if (h) begin
                void'(mchain.pop_front());
                mchain.push_back(d);
            end else if (u) begin
                for (int i = 0; i < N; i++) mupd[i] = mchain[i];
            end
        end
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] v35;
        logic [N-1:0] vc3;
        for (int i = 0; i < N; i++) mchain.push_back(1'b0);
        mupd = URST;
        v35 = 8'h35;
        vc3 = 8'hC3;
        @(posedge tck); #1;

        // Reset held two cycles, then confirm update register reset value through EXTEST
        cycle(0, 1, 1, 0, 0, 0, 1, 8'h12, 8'h9E);
        check("reset_pad_follows_core", seen_pad, 8'h90);
        cycle(0, 1, 1, 0, 1, 0, 1, 8'h12, 8'h6B);
        check("reset_tdo", {7'b0, seen_tdo}, 8'h00);
        cycle(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'hFF);
        check("reset_upd", seen_pad, 8'h00);

        // SAMPLE: capture then shift out LSB first
        cycle(1, 1, 0, 1, 0, 0, 0, 8'hA5, 8'h3C);
        for (int k = 0; k < N; k++) begin
            cycle(1, 1, 0, 0, 1, 0, 0, 8'hA5, 8'h3C);
            check("sample_tdo_bit", {7'b0, seen_tdo}, {7'b0, v35[k]});
        end

        // PRELOAD C3 then EXTEST drives it in the same cycle
        for (int k = 0; k < N; k++) cycle(1, 1, 0, 0, 1, 0, vc3[k], 8'h00, 8'h5A);
        cycle(1, 1, 0, 0, 0, 1, 0, 8'h00, 8'h5A);
        cycle(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h5A);
        check("extest_pad", seen_pad, 8'hC0);
        cycle(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h5A);
        check("extest_off_pad", seen_pad, 8'h50);

        // Gating: unselected strobes must not disturb the chain or update register
        for (int k = 0; k < N; k++) begin
            cycle(1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
            check("gated_tdo", {7'b0, seen_tdo}, 8'h01);
        end
        cycle(1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        cycle(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        check("gated_upd", seen_pad, 8'hC0);

        // Priority: capture beats shift (shift would have exposed a 1)
        cycle(1, 1, 0, 1, 1, 0, 1, 8'h00, 8'hF0);
        cycle(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'hF0);
        check("priority_tdo", {7'b0, seen_tdo}, 8'h00);

        // Mid-shift reset with EXTEST active: pads show update data, then core, never partial chain
        cycle(1, 1, 0, 1, 0, 0, 0, 8'hFF, 8'hFF);
        cycle(1, 1, 0, 0, 0, 1, 0, 8'hFF, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 1, 0, 1, 0, 0, 8'h00, 8'h00);
            check("midshift_pad", seen_pad, 8'hF0);
        end
        cycle(0, 1, 1, 0, 1, 0, 0, 8'h00, 8'h30);
        check("midshift_reset_pad", seen_pad, 8'h30);
        cycle(1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        check("after_reset_upd", seen_pad, 8'h00);
        for (int k = 0; k < N; k++) begin
            cycle(1, 1, 0, 0, 1, 0, 1, 8'h00, 8'h00);
            check("after_reset_chain", {7'b0, seen_tdo}, 8'h00);
        end

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 5) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                  1'($urandom), N'($urandom), N'($urandom));
        end

        @(negedge tck);
        check("scoreboard_drained", N'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
